// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: independent write and read FSMs over a shared
// word-addressed array, FIXED/INCR/WRAP bursts with byte strobes.
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [LEN_WIDTH-1:0]    AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [LEN_WIDTH-1:0]    ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFS = $clog2(NB);
  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [2:0]            size,
    input logic [1:0]            burst,
    input logic [LEN_WIDTH-1:0]  len
  );
    logic [ADDR_WIDTH-1:0] bytes, bound, base, nxt;
    bytes = ADDR_WIDTH'(1) << size;
    bound = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
    base  = a & ~(bound - ADDR_WIDTH'(1));
    nxt   = (a & ~(bytes - ADDR_WIDTH'(1))) + bytes;
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (nxt == base + bound) ? base : nxt;
      default: next_addr = nxt;
    endcase
  endfunction

  function automatic logic hdr_err(
    input logic [2:0]           size,
    input logic [1:0]           burst,
    input logic [LEN_WIDTH-1:0] len
  );
    logic len_ok;
    len_ok = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
             (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
    return (burst == 2'b11) || (size > 3'(OFFS)) ||
           (burst == 2'b10 && !len_ok);
  endfunction

  function automatic logic oob(input logic [ADDR_WIDTH-1:0] a);
    return (a >> OFFS) >= ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  // Write path
  w_state_t              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [LEN_WIDTH-1:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_hdr_q, w_hdr_d, w_err_q, w_err_d;
  logic                  w_we, w_last_beat;

  assign w_last_beat = (w_cnt_q == w_len_q);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_hdr_d   = w_hdr_q;
    w_err_d   = w_err_q;
    w_we      = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (AWVALID) begin
        w_id_d    = AWID;
        w_addr_d  = AWADDR;
        w_len_d   = AWLEN;
        w_size_d  = AWSIZE;
        w_burst_d = AWBURST;
        w_cnt_d   = '0;
        w_hdr_d   = hdr_err(AWSIZE, AWBURST, AWLEN);
        w_err_d   = w_hdr_d;
        w_state_d = W_DATA;
      end
      W_DATA: if (WVALID) begin
        // Header errors block every beat; out-of-range blocks only its own.
        w_we     = !w_hdr_q && !oob(w_addr_q);
        w_err_d  = w_err_q || oob(w_addr_q) || (WLAST != w_last_beat);
        w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q, w_len_q);
        w_cnt_d  = w_cnt_q + LEN_WIDTH'(1);
        if (w_last_beat) w_state_d = W_RESP;
      end
      W_RESP: if (BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_hdr_q   <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_hdr_q   <= w_hdr_d;
      w_err_q   <= w_err_d;
    end
  end

  always_ff @(posedge ACLK) begin
    for (int b = 0; b < NB; b++)
      if (w_we && !ARESET && WSTRB[b])
        mem[w_addr_q[OFFS +: IDXW]][8*b +: 8] <= WDATA[8*b +: 8];
  end

  assign AWREADY = (w_state_q == W_IDLE) && !ARESET;
  assign WREADY  = (w_state_q == W_DATA) && !ARESET;
  assign BVALID  = (w_state_q == W_RESP) && !ARESET;
  assign BID     = w_id_q;
  assign BRESP   = w_err_q ? SLVERR : OKAY;

  // Read path
  r_state_t              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_nxt;
  logic [LEN_WIDTH-1:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d, r_bad;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    r_nxt     = r_addr_q;
    r_bad     = 1'b0;
    unique case (r_state_q)
      R_IDLE: if (ARVALID) begin
        r_id_d    = ARID;
        r_addr_d  = ARADDR;
        r_len_d   = ARLEN;
        r_size_d  = ARSIZE;
        r_burst_d = ARBURST;
        r_cnt_d   = '0;
        r_bad     = hdr_err(ARSIZE, ARBURST, ARLEN) || oob(ARADDR);
        rdata_d   = r_bad ? '0 : mem[ARADDR[OFFS +: IDXW]];
        rresp_d   = r_bad ? SLVERR : OKAY;
        rlast_d   = (ARLEN == '0);
        r_state_d = R_DATA;
      end
      R_DATA: if (RREADY) begin
        if (rlast_q) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          // Once a beat errors, the rest of the burst stays SLVERR.
          r_nxt    = next_addr(r_addr_q, r_size_q, r_burst_q, r_len_q);
          r_addr_d = r_nxt;
          r_cnt_d  = r_cnt_q + LEN_WIDTH'(1);
          r_bad    = (rresp_q == SLVERR) || oob(r_nxt);
          rdata_d  = r_bad ? '0 : mem[r_nxt[OFFS +: IDXW]];
          rresp_d  = r_bad ? SLVERR : OKAY;
          rlast_d  = (r_cnt_d == r_len_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign ARREADY = (r_state_q == R_IDLE) && !ARESET;
  assign RVALID  = (r_state_q == R_DATA) && !ARESET;
  assign RID     = r_id_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem.
// Each scenario task drives its own stimulus and checks inline.
module tb_axi_slave_mem;
  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  axi_slave_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    int n = 0;
    AWID = id; AWADDR = addr; AWLEN = len;
    AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    while (AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
    n_checks++;
    if (AWREADY !== 1'b1) begin
      n_fails++;
      $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY);
    end
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    int n = 0;
    ARID = id; ARADDR = addr; ARLEN = len;
    ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    while (ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
    n_checks++;
    if (ARREADY !== 1'b1) begin
      n_fails++;
      $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY);
    end
    tick();
    ARVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
    int n = 0;
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    while (WREADY !== 1'b1 && n < 50) begin tick(); n++; end
    n_checks++;
    if (WREADY !== 1'b1) begin
      n_fails++;
      $display("FAIL w_timeout: WREADY=%b required 1", WREADY);
    end
    tick();
    WVALID = 1'b0;
  endtask

  task automatic b_recv(input logic [3:0] id, input logic [1:0] resp,
                        input string name);
    int n = 0;
    BREADY = 1'b1;
    while (BVALID !== 1'b1 && n < 50) begin tick(); n++; end
    n_checks++;
    if (BVALID !== 1'b1 || BID !== id || BRESP !== resp) begin
      n_fails++;
      $display("FAIL %s_b: BVALID=%b BID=%h BRESP=%b required 1 %h %b",
               name, BVALID, BID, BRESP, id, resp);
    end
    tick();
    BREADY = 1'b0;
    n_checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
      n_fails++;
      $display("FAIL %s_b_done: BVALID=%b AWREADY=%b required 0 1",
               name, BVALID, AWREADY);
    end
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] data,
                        input logic last, input logic [1:0] resp,
                        input string name, output int waits);
    int n = 0;
    RREADY = 1'b1;
    while (RVALID !== 1'b1 && n < 50) begin tick(); n++; end
    waits = n;
    n_checks++;
    if (RVALID !== 1'b1 || RID !== id || RDATA !== data ||
        RLAST !== last || RRESP !== resp) begin
      n_fails++;
      $display("FAIL %s_r: RVALID=%b RID=%h RDATA=%h RLAST=%b RRESP=%b required 1 %h %h %b %b",
               name, RVALID, RID, RDATA, RLAST, RRESP, id, data, last, resp);
    end
    tick();
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    tick();
    n_checks++;
    if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST} !== 6'b0 ||
        BID !== 4'h0 || RID !== 4'h0 || BRESP !== 2'b00 ||
        RRESP !== 2'b00 || RDATA !== 32'h0) begin
      n_fails++;
      $display("FAIL reset_state: rdy/vld=%b BID=%h RID=%h BRESP=%b RRESP=%b RDATA=%h required all 0",
               {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST},
               BID, RID, BRESP, RRESP, RDATA);
    end
    tick();
    ARESET = 1'b0;
    #1;
    n_checks++;
    if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_release: AWREADY=%b ARREADY=%b required 1 1",
               AWREADY, ARREADY);
    end
  endtask

  task automatic test_single();
    int w;
    aw_send(4'h1, 32'h10, 8'd0, 3'd2, INCR);
    n_checks++;
    if (WREADY !== 1'b1) begin
      n_fails++;
      $display("FAIL single_wready_lat: WREADY=%b required 1", WREADY);
    end
    w_send(32'hDEADBEEF, 4'hF, 1'b1);
    n_checks++;
    if (BVALID !== 1'b1) begin
      n_fails++;
      $display("FAIL single_bvalid_lat: BVALID=%b required 1", BVALID);
    end
    b_recv(4'h1, 2'b00, "single");
    ar_send(4'h2, 32'h10, 8'd0, 3'd2, INCR);
    r_beat(4'h2, 32'hDEADBEEF, 1'b1, 2'b00, "single", w);
    RREADY = 1'b0;
    n_checks++;
    if (w != 0) begin
      n_fails++;
      $display("FAIL single_rvalid_lat: waited %0d required 0", w);
    end
  endtask

  task automatic test_incr_burst();
    int w;
    int tot = 0;
    aw_send(4'h5, 32'h100, 8'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) w_send(32'(i + 1), 4'hF, i == 3);
    b_recv(4'h5, 2'b00, "incr");
    ar_send(4'h9, 32'h100, 8'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) begin
      r_beat(4'h9, 32'(i + 1), i == 3, 2'b00, "incr", w);
      tot += w;
    end
    RREADY = 1'b0;
    n_checks++;
    if (tot != 0 || RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      n_fails++;
      $display("FAIL incr_rate: stalls=%0d RVALID=%b ARREADY=%b required 0 0 1",
               tot, RVALID, ARREADY);
    end
  endtask

  task automatic test_wrap();
    int w;
    logic [31:0] seq [4];
    aw_send(4'h1, 32'h18, 8'd3, 3'd2, WRAP);
    for (int i = 0; i < 4; i++) w_send(32'hA0 + 32'(i), 4'hF, i == 3);
    b_recv(4'h1, 2'b00, "wrap");
    seq = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
    ar_send(4'h3, 32'h10, 8'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++)
      r_beat(4'h3, seq[i], i == 3, 2'b00, "wrap_lin", w);
    ar_send(4'h3, 32'h18, 8'd3, 3'd2, WRAP);
    for (int i = 0; i < 4; i++)
      r_beat(4'h3, 32'hA0 + 32'(i), i == 3, 2'b00, "wrap_rd", w);
    RREADY = 1'b0;
    aw_send(4'h1, 32'h10, 8'd2, 3'd2, WRAP);
    for (int i = 0; i < 3; i++) w_send(32'hFFFFFFFF, 4'hF, i == 2);
    b_recv(4'h1, 2'b10, "wrap_len2");
    ar_send(4'h3, 32'h10, 8'd1, 3'd2, INCR);
    r_beat(4'h3, 32'hA2, 1'b0, 2'b00, "wrap_len2_mem0", w);
    r_beat(4'h3, 32'hA3, 1'b1, 2'b00, "wrap_len2_mem1", w);
    RREADY = 1'b0;
  endtask

  task automatic test_strobe();
    int w;
    aw_send(4'h2, 32'h40, 8'd0, 3'd2, INCR);
    w_send(32'h11111111, 4'hF, 1'b1);
    b_recv(4'h2, 2'b00, "strb_init");
    aw_send(4'h2, 32'h40, 8'd0, 3'd2, INCR);
    w_send(32'hAABBCCDD, 4'b0101, 1'b1);
    b_recv(4'h2, 2'b00, "strb");
    ar_send(4'h2, 32'h40, 8'd0, 3'd2, INCR);
    r_beat(4'h2, 32'h11BB11DD, 1'b1, 2'b00, "strb", w);
    RREADY = 1'b0;
  endtask

  task automatic test_errors();
    int w;
    aw_send(4'h4, 32'h1000, 8'd0, 3'd2, INCR);
    w_send(32'h12345678, 4'hF, 1'b1);
    b_recv(4'h4, 2'b10, "oob_wr");
    ar_send(4'h4, 32'h1000, 8'd0, 3'd2, INCR);
    r_beat(4'h4, 32'h0, 1'b1, 2'b10, "oob_rd", w);
    RREADY = 1'b0;
    aw_send(4'h6, 32'h200, 8'd3, 3'd2, INCR);
    w_send(32'h1, 4'hF, 1'b0);
    w_send(32'h2, 4'hF, 1'b1);
    w_send(32'h3, 4'hF, 1'b0);
    n_checks++;
    if (BVALID !== 1'b0) begin
      n_fails++;
      $display("FAIL wlast_early_b: BVALID=%b required 0", BVALID);
    end
    w_send(32'h4, 4'hF, 1'b1);
    b_recv(4'h6, 2'b10, "wlast");
    aw_send(4'h7, 32'h40, 8'd0, 3'd2, 2'b11);
    w_send(32'h0, 4'hF, 1'b1);
    b_recv(4'h7, 2'b10, "burst11");
    aw_send(4'h7, 32'h40, 8'd0, 3'd3, INCR);
    w_send(32'h0, 4'hF, 1'b1);
    b_recv(4'h7, 2'b10, "size8");
    ar_send(4'h7, 32'h40, 8'd0, 3'd2, INCR);
    r_beat(4'h7, 32'h11BB11DD, 1'b1, 2'b00, "err_nowrite", w);
    RREADY = 1'b0;
  endtask

  task automatic test_bresp_backpressure();
    aw_send(4'h3, 32'h300, 8'd0, 3'd2, INCR);
    w_send(32'hCAFEF00D, 4'hF, 1'b1);
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (BVALID !== 1'b1 || BID !== 4'h3 || BRESP !== 2'b00 ||
          AWREADY !== 1'b0) begin
        n_fails++;
        $display("FAIL b_stall%0d: BVALID=%b BID=%h BRESP=%b AWREADY=%b required 1 3 00 0",
                 c, BVALID, BID, BRESP, AWREADY);
      end
      tick();
    end
    b_recv(4'h3, 2'b00, "b_stall");
  endtask

  task automatic test_rready_toggle();
    logic [15:0] pat = 16'b1001_0110_0100_1010;
    int beat = 0;
    ar_send(4'hA, 32'h100, 8'd3, 3'd2, INCR);
    for (int c = 0; c < 40 && beat < 4; c++) begin
      logic hs;
      RREADY = pat[c % 16];
      n_checks++;
      if (RVALID !== 1'b1 || RDATA !== 32'(beat + 1) ||
          RLAST !== (beat == 3) || RID !== 4'hA) begin
        n_fails++;
        $display("FAIL r_toggle c%0d: RVALID=%b RDATA=%h RLAST=%b RID=%h required 1 %h %b a",
                 c, RVALID, RDATA, RLAST, RID, 32'(beat + 1), beat == 3);
      end
      hs = RREADY;
      tick();
      if (hs) beat++;
    end
    RREADY = 1'b0;
    n_checks++;
    if (beat != 4 || RVALID !== 1'b0) begin
      n_fails++;
      $display("FAIL r_toggle_end: beats=%0d RVALID=%b required 4 0",
               beat, RVALID);
    end
  endtask

  task automatic test_reset_mid_read();
    int w;
    ar_send(4'hB, 32'h100, 8'd3, 3'd2, INCR);
    r_beat(4'hB, 32'h1, 1'b0, 2'b00, "rst_mid", w);
    RREADY = 1'b0;
    ARESET = 1'b1;
    tick();
    n_checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_mid_abort: RVALID=%b ARREADY=%b required 0 0",
               RVALID, ARREADY);
    end
    ARESET = 1'b0;
    #1;
    n_checks++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_mid_release: ARREADY=%b RVALID=%b required 1 0",
               ARREADY, RVALID);
    end
    ar_send(4'hC, 32'h104, 8'd0, 3'd2, FIXED);
    r_beat(4'hC, 32'h2, 1'b1, 2'b00, "rst_mid_after", w);
    RREADY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_wrap();
    test_strobe();
    test_errors();
    test_bresp_backpressure();
    test_rready_toggle();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
